// File: rtl/seq_mult_ctrl.sv
// Sequential shift-add multiplier with internal control FSM and start/done handshake.
// Supports unsigned and two's-complement operands of generic width via magnitude/sign split.
module seq_mult_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   da,
    input  logic [WIDTH-1:0]   db,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]         state;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               neg;

    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_next;

    // Magnitude of the operand; -2^(WIDTH-1) maps onto itself, which is correct as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic en);
        return (en && v[WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    // One shift-add step: the WIDTH+1 bit sum keeps the carry, which is shifted into the MSB.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (b[0] ? {1'b0, a} : {(WIDTH+1){1'b0}});
        acc_next = {sum, acc[WIDTH-1:1]};
    end

    assign busy = (state == CALC) || (state == FIX);

    always_ff @(posedge clk) begin
        if (!clr) begin
            state <= IDLE;
            a     <= '0;
            b     <= '0;
            acc   <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
            done  <= 1'b0;
            p     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a     <= magnitude(da, signed_mode);
                        b     <= magnitude(db, signed_mode);
                        neg   <= signed_mode & (da[WIDTH-1] ^ db[WIDTH-1]);
                        acc   <= '0;
                        cnt   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    b   <= b >> 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    p     <= apply_sign(acc, neg);
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Scoreboard bench for seq_mult_ctrl: WIDTH=4 directed vectors and WIDTH=8 reference-model sweep.
// Expected products/done cycles are queued at issue; a forked monitor pops them on every done.
module tb_seq_mult_ctrl;

    typedef struct {
        logic [15:0] p;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr;
    logic        start4, mode4, busy4, done4;
    logic [3:0]  da4, db4;
    logic [7:0]  p4;
    logic        start8, mode8, busy8, done8;
    logic [7:0]  da8, db8;
    logic [15:0] p8;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q4[$];
    exp_t q8[$];

    seq_mult_ctrl #(.WIDTH(4)) u4 (
        .clk(clk), .clr(clr), .start(start4), .signed_mode(mode4),
        .da(da4), .db(db4), .busy(busy4), .done(done4), .p(p4)
    );

    seq_mult_ctrl #(.WIDTH(8)) u8 (
        .clk(clk), .clr(clr), .start(start8), .signed_mode(mode8),
        .da(da8), .db(db8), .busy(busy8), .done(done8), .p(p8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (done4) begin
                if (q4.size() == 0) check("done4_unexpected", 64'd1, 64'd0);
                else begin
                    e = q4.pop_front();
                    check("p4", 64'(p4), 64'(e.p));
                    check("lat4", 64'(cyc), 64'(e.cyc));
                end
            end
            if (done8) begin
                if (q8.size() == 0) check("done8_unexpected", 64'd1, 64'd0);
                else begin
                    e = q8.pop_front();
                    check("p8", 64'(p8), 64'(e.p));
                    check("lat8", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    endtask

    // Issue one WIDTH=4 operation and follow it to its done cycle, checking busy each cycle.
    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic m, input logic [7:0] e);
        exp_t x;
        @(negedge clk);
        da4 = a; db4 = b; mode4 = m; start4 = 1'b1;
        x.p = 16'(e); x.cyc = cyc + 6;
        q4.push_back(x);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start4 = 1'b0;
            check("busy4_high", 64'(busy4), 64'd1);
        end
        @(negedge clk);
        check("busy4_low_at_done", 64'(busy4), 64'd0);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic m);
        exp_t x;
        logic signed [31:0] sa, sb, prod;
        if (m) begin
            sa = 32'($signed(a));
            sb = 32'($signed(b));
        end else begin
            sa = 32'(a);
            sb = 32'(b);
        end
        prod = sa * sb;
        @(negedge clk);
        da8 = a; db8 = b; mode8 = m; start8 = 1'b1;
        x.p = prod[15:0]; x.cyc = cyc + 10;
        q8.push_back(x);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start8 = 1'b0;
        end
    endtask

    initial begin
        exp_t x;
        clr = 1'b0;
        start4 = 1'b0; mode4 = 1'b0; da4 = '0; db4 = '0;
        start8 = 1'b0; mode8 = 1'b0; da8 = '0; db8 = '0;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        check("rst_busy4", 64'(busy4), 64'd0);
        check("rst_done4", 64'(done4), 64'd0);
        check("rst_p4", 64'(p4), 64'd0);
        check("rst_busy8", 64'(busy8), 64'd0);
        check("rst_p8", 64'(p8), 64'd0);
        clr = 1'b1;

        // Unsigned full-scale, then result must hold.
        op4(4'd15, 4'd15, 1'b0, 8'hE1);
        repeat (3) @(negedge clk);
        check("p4_held", 64'(p4), 64'hE1);

        // Signed cases including most-negative operands.
        op4(4'b1000, 4'b1000, 1'b1, 8'h40);
        op4(4'hD, 4'd5, 1'b1, 8'hF1);
        op4(4'd7, 4'hF, 1'b1, 8'hF9);

        // Zero operands.
        op4(4'd9, 4'd0, 1'b0, 8'h00);
        op4(4'd0, 4'hB, 1'b1, 8'h00);

        // start held high: second op accepted exactly in the done cycle.
        @(negedge clk);
        da4 = 4'd3; db4 = 4'd4; mode4 = 1'b0; start4 = 1'b1;
        x.p = 16'h0C; x.cyc = cyc + 6;  q4.push_back(x);
        x.p = 16'h2A; x.cyc = cyc + 12; q4.push_back(x);
        @(negedge clk);
        da4 = 4'd6; db4 = 4'd7;
        repeat (5) @(negedge clk);
        check("hs_busy_low_done", 64'(busy4), 64'd0);
        @(negedge clk);
        check("hs_busy_second", 64'(busy4), 64'd1);
        start4 = 1'b0;
        repeat (6) @(negedge clk);

        // Reset mid-operation: aborted op never signals done and p clears.
        @(negedge clk);
        da4 = 4'd13; db4 = 4'd11; mode4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        check("abort_busy", 64'(busy4), 64'd0);
        check("abort_done", 64'(done4), 64'd0);
        check("abort_p", 64'(p4), 64'd0);
        repeat (8) @(negedge clk);
        check("abort_p_still0", 64'(p4), 64'd0);
        op4(4'd2, 4'd3, 1'b0, 8'h06);

        // WIDTH=8 corners then random sweep against the reference model.
        op8(8'h80, 8'h80, 1'b1);
        op8(8'hFF, 8'hFF, 1'b0);
        op8(8'hFF, 8'hFF, 1'b1);
        op8(8'h7F, 8'h80, 1'b1);
        for (int i = 0; i < 500; i++) begin
            op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        check("q4_drained", 64'(q4.size()), 64'd0);
        check("q8_drained", 64'(q8.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_mult_ctrl.md
Name: seq_mult_ctrl

Overview:
- Parametrised sequential shift-add multiplier with an integrated control FSM and a start/done handshake.
- Successor to the 4-bit externally-sequenced multiplier datapath. The load, shift and product-load strobes are now generated internally; callers no longer drive them.
- Adds a selectable two's-complement mode and a generic operand width.
- Sits between register-file/ALU operand sources and the result writeback path.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..32. Product width is 2*WIDTH.

Ports:
- clk  in  1  rising-edge clock
- clr  in  1  synchronous reset, active-low (sampled on rising clk; 0 = reset)
- start  in  1  request; sampled only in IDLE
- signed_mode  in  1  0 = unsigned operands, 1 = two's-complement operands; captured with start
- da  in  WIDTH  multiplicand; captured with start
- db  in  WIDTH  multiplier; captured with start
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse; p is valid from this cycle onward
- p  out  2*WIDTH  product, registered, held until the next result

Behaviour:
- Reset (clr=0 at a rising edge): state=IDLE, busy=0, done=0, p=0, all internal registers=0. Reset takes priority over everything, including mid-operation; an aborted operation never asserts done.
- States: IDLE, CALC, FIX.
- IDLE, start=0: remain in IDLE.
- IDLE -> CALC on the edge where start=1 (edge E0). On E0:
  - capture the mode;
  - A <= |da|, B <= |db| (magnitudes taken when signed_mode=1, raw values otherwise);
  - neg <= signed_mode & (da[MSB] ^ db[MSB]);
  - acc <= 0, cnt <= 0.
- CALC: on each edge E1..EWIDTH:
  - if B[0]=1, add A into the upper WIDTH bits of acc;
  - right-shift {carry, acc} by 1 so the carry enters the MSB;
  - right-shift B by 1;
  - cnt++.
  - After cnt reaches WIDTH-1 and that step is done (edge EWIDTH), go to FIX.
- FIX: on edge E(WIDTH+1):
  - p <= neg ? (~acc + 1) : acc, truncated to 2*WIDTH bits;
  - done <= 1;
  - state <= IDLE.
- done is high for exactly one cycle, following E(WIDTH+1). It is deasserted on the next edge regardless of start.
- Latency: done rises WIDTH+1 clock cycles after the edge that samples start (5 cycles for WIDTH=4).
- Throughput: one operation per WIDTH+2 cycles. A start asserted in the cycle where done=1 is accepted, since the state is already IDLE.
- busy is 1 from after E0 through the edge E(WIDTH+1), i.e. busy=1 while state is CALC or FIX.
- start while busy=1 is ignored. Operand and mode inputs are don't-care outside the E0 sample.
- Width rules:
  - Magnitude of the most negative input, -2^(WIDTH-1), fits in WIDTH unsigned bits; no special case is needed.
  - The accumulator add is WIDTH+1 bits wide, so the carry is never lost.
  - Every result fits in 2*WIDTH bits in both modes; no overflow flag is provided.
- Zero operand in signed mode: the negated zero is zero, so p=0.
- p changes only on the FIX edge or on reset.

Test Plan:
- WIDTH=4, unsigned, da=15, db=15, start for 1 cycle -> busy high for 5 cycles, done pulse 5 cycles after start edge, p=0xE1 (225), held after done.
- WIDTH=4, signed, da=4'b1000 (-8), db=4'b1000 (-8) -> p=0x40 (+64); then da=-3 (4'hD), db=5 -> p=0xF1 (-15); da=7, db=-1 -> p=0xF9 (-7).
- WIDTH=4, unsigned da=9, db=0 and da=0, signed db=-5 -> p=0x00 in both cases; done still pulses at latency 5.
- Handshake: start held high continuously with alternating operands (3*4, then 6*7) -> second operation accepted only in the done cycle; p=0x0C, then 0x2A; start pulses during busy change neither p nor timing.
- Reset mid-operation: start 13*11, drive clr=0 at cycle 3 for 1 cycle -> busy=0, done never pulses, p=0; next start 2*3 -> p=0x06 with normal latency.
- WIDTH=8 randomized: 500 random operand/mode pairs against a reference product model -> all p match; every done occurs exactly 9 cycles after its start edge.
